// File: rtl/gcm_pkg.sv
// Shared types and helpers for the GCM counter-mode scheduler.
// The optional GCM_SCHED_ASSERT_EN checks live in gcm_ctr_scheduler.sv.
`timescale 1ns/1ps
package gcm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  localparam int unsigned DEF_MAX_BATCH  = 5;
  localparam int unsigned DEF_FIFO_DEPTH = 8;
  localparam int unsigned DEF_LEN_W      = 16;

  // GCM inc32: only the low word counts, and it wraps silently.
  function automatic logic [127:0] inc32(input logic [127:0] blk);
    return {blk[127:32], blk[31:0] + 32'd1};
  endfunction

endpackage

// File: rtl/gcm_ks_fifo.sv
// Keystream FIFO, 128-bit entries, DEPTH deep (DEPTH >= 2).
// Pushes when full and pops when empty are ignored.
`timescale 1ns/1ps
module gcm_ks_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [127:0]                 push_data,
  input  logic                         pop,
  output logic [127:0]                 head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   free_count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [127:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign head       = mem[rd_ptr];
  assign free_count = CW'(DEPTH) - count;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: the array is deliberately not reset; count/pointers alone say which
  // entries are valid, and a reset-free array can map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/gcm_ctr_scheduler.sv
// Drives AES_main with inc32 counter blocks in bursts and buffers the keystream.
// Define GCM_SCHED_ASSERT_EN to compile simulation assertions and batch timing reports.
`timescale 1ns/1ps
module gcm_ctr_scheduler
  import gcm_pkg::*;
#(
  parameter int unsigned MAX_BATCH  = DEF_MAX_BATCH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned LEN_W      = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [127:0]     req_key,
  input  logic [127:0]     req_j0,
  input  logic [LEN_W-1:0] req_nblk,
  output logic             aes_start,
  output logic [127:0]     aes_key,
  output logic [127:0]     aes_data_in,
  output logic [31:0]      aes_data_total,
  input  logic             aes_first_block_finish,
  input  logic [127:0]     aes_data_out,
  output logic             ks_valid,
  input  logic             ks_ready,
  output logic [127:0]     ks_data,
  output logic             ek0_valid,
  output logic [127:0]     ek0_data,
  output logic             busy,
  output logic             done
);
  localparam int unsigned BW = $clog2(MAX_BATCH + 1);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned RW = LEN_W + 1;

  state_t        state;
  logic [127:0]  ctr;
  logic [RW-1:0] remaining;
  logic [BW-1:0] batch;
  logic [BW-1:0] batch_q;
  logic [BW-1:0] issued;
  logic [BW-1:0] cap_idx;
  logic [CW-1:0] need;
  logic [CW-1:0] free_count;
  logic [127:0]  fifo_head;
  logic          j0_pending;
  logic          finish_q;
  logic          capturing;
  logic          ks_capture;
  logic          fifo_push;
  logic          fifo_full;
  logic          fifo_empty;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    batch = BW'(MAX_BATCH);
    if (remaining < RW'(MAX_BATCH)) batch = remaining[BW-1:0];
    // The J0 block goes to ek0_data, so it needs no FIFO slot.
    need = CW'(batch) - CW'(j0_pending);
  end

  assign ks_capture = (state == WAIT) && capturing && !(cap_idx == '0 && j0_pending);
  assign fifo_push  = ks_capture && !fifo_full;
  assign busy       = (state != IDLE);
  assign ks_valid   = !fifo_empty;
  assign ks_data    = ks_valid ? fifo_head : '0;

  gcm_ks_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_data  (aes_data_out),
    .pop        (ks_ready),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .free_count (free_count)
  );

  // NOTE: state is written with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      req_ready      <= 1'b0;
      aes_start      <= 1'b0;
      aes_key        <= '0;
      aes_data_in    <= '0;
      aes_data_total <= '0;
      ek0_valid      <= 1'b0;
      ek0_data       <= '0;
      done           <= 1'b0;
      ctr            <= '0;
      remaining      <= '0;
      batch_q        <= '0;
      issued         <= '0;
      cap_idx        <= '0;
      j0_pending     <= 1'b0;
      finish_q       <= 1'b0;
      capturing      <= 1'b0;
    end else begin
      aes_start <= 1'b0;
      done      <= 1'b0;
      finish_q  <= aes_first_block_finish;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            aes_key    <= req_key;
            ctr        <= req_j0;
            remaining  <= {1'b0, req_nblk} + RW'(1);
            j0_pending <= 1'b1;
            ek0_valid  <= 1'b0;
            issued     <= '0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          capturing <= 1'b0;
          cap_idx   <= '0;
          if (issued == '0) begin
            if (free_count >= need) begin
              aes_start      <= 1'b1;
              aes_data_in    <= ctr;
              aes_data_total <= 32'(batch);
              batch_q        <= batch;
              ctr            <= inc32(ctr);
              issued         <= BW'(1);
              if (batch == BW'(1)) begin
                issued <= '0;
                state  <= WAIT;
              end
            end
          end else begin
            aes_data_in <= ctr;
            ctr         <= inc32(ctr);
            issued      <= issued + BW'(1);
            if (issued + BW'(1) == batch_q) begin
              issued <= '0;
              state  <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!capturing) begin
            if (aes_first_block_finish && !finish_q) begin
              capturing <= 1'b1;
              cap_idx   <= '0;
            end
          end else begin
            if (cap_idx == '0 && j0_pending) begin
              ek0_data  <= aes_data_out;
              ek0_valid <= 1'b1;
            end
            cap_idx <= cap_idx + BW'(1);
            if (cap_idx + BW'(1) == batch_q) begin
              capturing  <= 1'b0;
              j0_pending <= 1'b0;
              remaining  <= remaining - RW'(batch_q);
              if (remaining == RW'(batch_q)) begin
                done      <= 1'b1;
                req_ready <= 1'b1;
                state     <= IDLE;
              end else begin
                state <= ISSUE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GCM_SCHED_ASSERT_EN
  logic [31:0] batch_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         batch_cycles <= '0;
    else if (aes_start) batch_cycles <= 32'd1;
    else                batch_cycles <= batch_cycles + 32'd1;
  end

  always @(posedge clk) begin
    if (rst_n && state == WAIT && capturing && cap_idx + BW'(1) == batch_q)
      $display("gcm_ctr_scheduler: batch of %0d blocks took %0d cycles", batch_q, batch_cycles);
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    ks_capture |-> !fifo_full);
  a_finish_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
    (aes_first_block_finish && !finish_q) |-> (state == WAIT));
  a_stable_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
    (state == WAIT && $past(state) == WAIT) |-> ($stable(aes_key) && $stable(aes_data_total)));
`endif

endmodule

// File: tb/tb_gcm_ctr_scheduler.sv
// Bench for gcm_ctr_scheduler: a mock AES_main, a queue-based reference model,
// a table of directed jobs, hand-written backpressure/reset sequences and random jobs.
`timescale 1ns/1ps
module tb_gcm_ctr_scheduler;

  localparam int MAXB   = 5;
  localparam int FDEPTH = 8;

  localparam logic [127:0] TC_KEY  = 128'hfeffe9928665731c6d6a8f9467308308;
  localparam logic [127:0] TC_J0   = 128'h3bab75780a31c059f83d2a44752f9863;
  localparam logic [127:0] WRAP_J0 = 128'h3bab75780a31c059f83d2a44ffffffff;
  localparam logic [127:0] TC_KS [5] = '{
    128'h7dc63b399f2d98d57ab073b6baa4138e,
    128'h55d37bbd9ad21353a6f93a690eca9e0e,
    128'h3836bbf6d696e672946a1a01404fa6d5,
    128'h1dd8a5316ecc35c3e313bca59d2ac94a,
    128'h6742982706a9f154f657d5dc94b746db
  };

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [127:0] req_key;
  logic [127:0] req_j0;
  logic [15:0]  req_nblk;
  logic         aes_start;
  logic [127:0] aes_key;
  logic [127:0] aes_data_in;
  logic [31:0]  aes_data_total;
  logic         aes_first_block_finish;
  logic [127:0] aes_data_out;
  logic         ks_valid;
  logic         ks_ready;
  logic [127:0] ks_data;
  logic         ek0_valid;
  logic [127:0] ek0_data;
  logic         busy;
  logic         done;

  gcm_ctr_scheduler dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .req_valid              (req_valid),
    .req_ready              (req_ready),
    .req_key                (req_key),
    .req_j0                 (req_j0),
    .req_nblk               (req_nblk),
    .aes_start              (aes_start),
    .aes_key                (aes_key),
    .aes_data_in            (aes_data_in),
    .aes_data_total         (aes_data_total),
    .aes_first_block_finish (aes_first_block_finish),
    .aes_data_out           (aes_data_out),
    .ks_valid               (ks_valid),
    .ks_ready               (ks_ready),
    .ks_data                (ks_data),
    .ek0_valid              (ek0_valid),
    .ek0_data               (ek0_data),
    .busy                   (busy),
    .done                   (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Counter block j0 advanced by i under the inc32 rule, as plain modular arithmetic.
  function automatic logic [127:0] add32(input logic [127:0] j, input int i);
    return {j[127:96], j[95:32], j[31:0] + 32'(i)};
  endfunction

  // Stand-in for AES: known test-vector blocks for the reference key, a keyed scramble otherwise.
  function automatic logic [127:0] mock_aes(input logic [127:0] k, input logic [127:0] b);
    if (k == TC_KEY) begin
      for (int i = 1; i <= 5; i++)
        if (b == add32(TC_J0, i)) return TC_KS[i-1];
    end
    return {b[95:0], b[127:96]} ^ k ^ 128'hc3a5_5a3c_0f1e_e1f0_9669_6996_a55a_3cc3;
  endfunction

  // Reference model state
  logic [127:0] cur_key;
  logic [127:0] exp_in[$];
  int           exp_tot[$];
  logic [127:0] exp_ks[$];
  logic [127:0] got_ks[$];
  logic [127:0] job_ek0;
  int           job_nblk;
  int           job_model_starts;
  int           job_starts0;
  int           job_done0;
  int           starts = 0;
  int           done_cnt = 0;
  int           ready_mode = 1;  // 0 never, 1 always, 2 random

  // Mock AES_main
  int           ph;
  int           tot;
  int           idx;
  int           wcnt;
  logic [127:0] blk_q[$];

  task automatic take_block();
    blk_q.push_back(aes_data_in);
    if (exp_in.size() == 0) check("issue_extra", 128'(1), 128'(0));
    else check("aes_data_in", aes_data_in, exp_in.pop_front());
    if (blk_q.size() >= tot) begin
      ph   = 2;
      wcnt = $urandom_range(3, 0);
    end else begin
      ph = 1;
    end
  endtask

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0;
      idx = 0;
      wcnt = 0;
      tot = 0;
      blk_q.delete();
      aes_first_block_finish = 1'b0;
      aes_data_out = '0;
    end else begin
      case (ph)
        0: if (aes_start) begin
          starts++;
          blk_q.delete();
          check("aes_key", aes_key, cur_key);
          if (exp_tot.size() == 0) check("start_extra", 128'(1), 128'(0));
          else check("aes_data_total", 128'(aes_data_total), 128'(exp_tot.pop_front()));
          tot = int'(aes_data_total);
          take_block();
        end
        1: begin
          check("start_in_burst", 128'(aes_start), 128'(0));
          take_block();
        end
        2: if (wcnt == 0) begin
          aes_first_block_finish = 1'b1;
          idx = 0;
          ph  = 3;
        end else begin
          wcnt--;
        end
        default: if (idx < tot) begin
          aes_data_out = (idx < blk_q.size()) ? mock_aes(aes_key, blk_q[idx]) : '0;
          idx++;
        end else begin
          aes_first_block_finish = 1'b0;
          aes_data_out = {$urandom, $urandom, $urandom, $urandom};
          ph = 0;
        end
      endcase
    end
  end

  // Keystream consumer and done monitor
  always @(negedge clk) begin
    logic rdy;
    rdy = (ready_mode == 1) || (ready_mode == 2 && $urandom_range(1, 0) == 1);
    ks_ready = rdy;
    if (rdy && ks_valid) begin
      got_ks.push_back(ks_data);
      if (exp_ks.size() == 0) check("ks_extra", 128'(1), 128'(0));
      else check("ks_data", ks_data, exp_ks.pop_front());
    end
    if (done) done_cnt++;
  end

  task automatic start_job(input logic [127:0] k, input logic [127:0] j, input int n);
    int rem;
    int b;
    int w;
    cur_key = k;
    exp_in.delete();
    exp_tot.delete();
    exp_ks.delete();
    got_ks.delete();
    for (int i = 0; i <= n; i++) exp_in.push_back(add32(j, i));
    for (int i = 1; i <= n; i++) exp_ks.push_back(mock_aes(k, add32(j, i)));
    rem = n + 1;
    while (rem > 0) begin
      b = (rem < MAXB) ? rem : MAXB;
      exp_tot.push_back(b);
      rem -= b;
    end
    job_model_starts = exp_tot.size();
    job_ek0     = mock_aes(k, j);
    job_nblk    = n;
    job_starts0 = starts;
    job_done0   = done_cnt;
    w = 0;
    while (!req_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("req_ready_wait", 128'(req_ready), 128'(1));
    req_valid = 1'b1;
    req_key   = k;
    req_j0    = j;
    req_nblk  = 16'(n);
    @(negedge clk);
    req_valid = 1'b0;
    check("ek0_cleared", 128'(ek0_valid), 128'(0));
    check("busy_after_accept", 128'(busy), 128'(1));
  endtask

  task automatic finish_job(input int exp_starts);
    int w;
    w = 0;
    while (done_cnt == job_done0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("done_seen", 128'(done_cnt != job_done0), 128'(1));
    repeat (3) @(negedge clk);
    check("done_single", 128'(done_cnt - job_done0), 128'(1));
    check("ek0_valid", 128'(ek0_valid), 128'(1));
    check("ek0_data", ek0_data, job_ek0);
    w = 0;
    while (exp_ks.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("ks_drained", 128'(exp_ks.size()), 128'(0));
    check("ks_count", 128'(got_ks.size()), 128'(job_nblk));
    check("issue_all", 128'(exp_in.size()), 128'(0));
    check("starts", 128'(starts - job_starts0), 128'(exp_starts));
  endtask

  task automatic check_tc_ks();
    for (int i = 0; i < 4; i++)
      check("tc_ks", (i < got_ks.size()) ? got_ks[i] : 128'h0, TC_KS[i]);
  endtask

  // Number of batches admitted before FIFO admission blocks, with no consumer.
  function automatic int stall_starts(input int n);
    int occ;
    int rem;
    int s;
    int b;
    int first;
    occ = 0;
    rem = n + 1;
    s = 0;
    first = 1;
    while (rem > 0) begin
      b = (rem < MAXB) ? rem : MAXB;
      if (FDEPTH - occ < b - first) break;
      occ += b - first;
      rem -= b;
      first = 0;
      s++;
    end
    return s;
  endfunction

  typedef struct {
    logic [127:0] key;
    logic [127:0] j0;
    int           nblk;
    int           mode;
    int           exp_starts;
    logic [127:0] exp_last;
    bit           has_last;
    bit           tc;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{TC_KEY, TC_J0,   4,  1, 1, TC_KS[3], 1'b1, 1'b1};
    vecs[1] = '{TC_KEY, TC_J0,   5,  1, 2, TC_KS[4], 1'b1, 1'b1};
    vecs[2] = '{TC_KEY, WRAP_J0, 2,  1, 1, 128'h0,   1'b0, 1'b0};
    vecs[3] = '{TC_KEY, TC_J0,   0,  1, 1, 128'h0,   1'b0, 1'b0};
    vecs[4] = '{TC_KEY, TC_J0,   9,  2, 2, 128'h0,   1'b0, 1'b0};
    vecs[5] = '{TC_KEY, TC_J0,   10, 2, 3, 128'h0,   1'b0, 1'b0};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_key   = '0;
    req_j0    = '0;
    req_nblk  = '0;
    ks_ready  = 1'b0;
    cur_key   = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 128'(req_ready), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_ks_valid", 128'(ks_valid), 128'(0));
    check("rst_aes_start", 128'(aes_start), 128'(0));
    check("rst_ek0_valid", 128'(ek0_valid), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("req_ready_after_rst", 128'(req_ready), 128'(1));

    for (int v = 0; v < 6; v++) begin
      ready_mode = vecs[v].mode;
      start_job(vecs[v].key, vecs[v].j0, vecs[v].nblk);
      finish_job(vecs[v].exp_starts);
      if (vecs[v].has_last)
        check("ks_last", (got_ks.size() > 0) ? got_ks[got_ks.size()-1] : 128'h0, vecs[v].exp_last);
      if (vecs[v].tc) check_tc_ks();
    end

    // Backpressure: no consumer, admission must block the next batch.
    ready_mode = 0;
    start_job(TC_KEY, TC_J0, 12);
    repeat (150) @(negedge clk);
    check("bp_stall_starts", 128'(starts - job_starts0), 128'(stall_starts(12)));
    check("bp_busy", 128'(busy), 128'(1));
    check("bp_no_start", 128'(aes_start), 128'(0));
    check("bp_ks_valid", 128'(ks_valid), 128'(1));
    ready_mode = 1;
    finish_job(3);

    // Reset in the middle of a capture.
    start_job(TC_KEY, TC_J0, 8);
    begin
      int w;
      w = 0;
      while (ph != 3 && w < 200) begin
        @(negedge clk);
        w++;
      end
      check("reach_capture", 128'(ph == 3), 128'(1));
    end
    #3 rst_n = 1'b0;
    #1;
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_ks_valid", 128'(ks_valid), 128'(0));
    check("abort_aes_key", aes_key, 128'h0);
    check("abort_data_in", aes_data_in, 128'h0);
    check("abort_flags", 128'({aes_start, ek0_valid, done, req_ready, aes_data_total}), 128'h0);
    exp_in.delete();
    exp_tot.delete();
    exp_ks.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_job(TC_KEY, TC_J0, 4);
    finish_job(1);
    check_tc_ks();

    // Random jobs against the reference model.
    for (int r = 0; r < 6; r++) begin
      logic [127:0] k;
      logic [127:0] j;
      int n;
      k = {$urandom, $urandom, $urandom, $urandom};
      j = {$urandom, $urandom, $urandom, $urandom};
      if (r % 2 == 1) j[31:0] = 32'hffff_fffe;
      n = $urandom_range(17, 0);
      ready_mode = 2;
      start_job(k, j, n);
      finish_job(job_model_starts);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
